// File: rtl/mem_arb_2x.sv
// Two-requester round-robin arbiter and command sequencer for the 512x8
// single-port RAM wrapper. Requester A is the CPU data port and requester B
// is the UART loader / debug port. One access is issued per cycle. A single
// bubble is inserted when a read hits the address of the write accepted in
// the previous cycle, because the RAM commits writes one edge late.
module mem_arb_2x #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_a_req,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_wdata,
    output logic          o_a_gnt,
    output logic          o_a_rvalid,
    output logic [DW-1:0] o_a_rdata,
    input  logic          i_b_req,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_wdata,
    output logic          o_b_gnt,
    output logic          o_b_rvalid,
    output logic [DW-1:0] o_b_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_mem_re,
    input  logic [DW-1:0] i_mem_rdata
);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    cmd_t          a_cmd, b_cmd, win;
    logic          last;      // 1: B was granted most recently
    logic          wr_pend;   // a write was accepted last cycle
    logic [AW-1:0] wr_addr;   // address of that write
    logic          a_rd, b_rd; // read-owner flags for the return cycle
    logic          pick_b, any_req, hazard, gnt;

    assign a_cmd = {i_a_we, i_a_addr, i_a_wdata};
    assign b_cmd = {i_b_we, i_b_addr, i_b_wdata};

    // Pick a winner, then suppress it if it is a read of the address still
    // being written; the loser is never promoted into the bubble cycle.
    always_comb begin
        pick_b      = i_b_req & (~i_a_req | ~last);
        any_req     = i_a_req | i_b_req;
        win         = pick_b ? b_cmd : a_cmd;
        hazard      = wr_pend & ~win.we & (win.addr == wr_addr);
        gnt         = any_req & ~hazard;
        o_a_gnt     = gnt & ~pick_b;
        o_b_gnt     = gnt & pick_b;
        o_mem_we    = gnt & win.we;
        o_mem_re    = gnt & ~win.we;
        o_mem_addr  = gnt ? win.addr  : '0;
        o_mem_wdata = gnt ? win.wdata : '0;
    end

    // Round-robin pointer, write-hazard tracking and read ownership.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last    <= 1'b1;
            wr_pend <= 1'b0;
            wr_addr <= '0;
            a_rd    <= 1'b0;
            b_rd    <= 1'b0;
        end else begin
            if (gnt) last <= pick_b;
            wr_pend <= o_mem_we;
            if (o_mem_we) wr_addr <= win.addr;
            a_rd <= o_a_gnt & ~win.we;
            b_rd <= o_b_gnt & ~win.we;
        end
    end

    assign o_a_rvalid = a_rd;
    assign o_b_rvalid = b_rd;
    assign o_a_rdata  = a_rd ? i_mem_rdata : '0;
    assign o_b_rdata  = b_rd ? i_mem_rdata : '0;

endmodule
